// File: rtl/fpu_pkg.sv
// Shared defaults and state encoding for the FP32 lane loader that feeds the
// 8-lane demux register bank.
package fpu_pkg;

    localparam int unsigned FPU_DATA_W = 32;
    localparam int unsigned FPU_LANES  = 8;
    localparam int unsigned FPU_SEL_W  = 3;

    typedef enum logic [1:0] {
        StFill   = 2'b00,
        StPad    = 2'b01,
        StSettle = 2'b10,
        StHold   = 2'b11
    } state_e;

endpackage

// File: rtl/fpu_lane_loader.sv
// Streams words into the demux bank one lane per accept, zero-pads short vectors
// and hands the complete vector downstream with a valid/ready pair.
module fpu_lane_loader
    import fpu_pkg::*;
#(
    parameter int unsigned DATA_W = FPU_DATA_W,
    parameter int unsigned LANES  = FPU_LANES,
    parameter int unsigned SEL_W  = FPU_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] mux_din,
    output logic [SEL_W-1:0]  mux_sel,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic [SEL_W:0]    vec_count
);

    localparam logic [SEL_W:0] LastLane = (SEL_W + 1)'(LANES - 1);
    localparam logic [SEL_W:0] One      = (SEL_W + 1)'(1);

    state_e            state_q, state_d;
    logic [SEL_W:0]    lane_idx_q, lane_idx_d;
    logic [SEL_W:0]    vec_count_q, vec_count_d;
    logic [DATA_W-1:0] mux_din_q, mux_din_d;
    logic [SEL_W-1:0]  mux_sel_q, mux_sel_d;
    logic              vec_valid_q, vec_valid_d;
    logic              accept;

    assign in_ready = (state_q == StFill);
    assign accept   = in_valid & in_ready;

    // The bank rewrites dout[sel] every cycle, so din/sel may only move on a lane write.
    always_comb begin
        state_d     = state_q;
        lane_idx_d  = lane_idx_q;
        vec_count_d = vec_count_q;
        mux_din_d   = mux_din_q;
        mux_sel_d   = mux_sel_q;
        vec_valid_d = vec_valid_q;
        case (state_q)
            StFill: begin
                if (accept) begin
                    mux_din_d   = in_data;
                    mux_sel_d   = lane_idx_q[SEL_W-1:0];
                    lane_idx_d  = lane_idx_q + One;
                    vec_count_d = vec_count_q + One;
                    if (lane_idx_q == LastLane) begin
                        state_d = StSettle;
                    end else if (in_last) begin
                        state_d = StPad;
                    end
                end
            end
            StPad: begin
                mux_din_d  = '0;
                mux_sel_d  = lane_idx_q[SEL_W-1:0];
                lane_idx_d = lane_idx_q + One;
                if (lane_idx_q == LastLane) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                vec_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (vec_ready) begin
                    vec_valid_d = 1'b0;
                    lane_idx_d  = '0;
                    vec_count_d = '0;
                    state_d     = StFill;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFill;
            lane_idx_q  <= '0;
            vec_count_q <= '0;
            mux_din_q   <= '0;
            mux_sel_q   <= '0;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_idx_q  <= lane_idx_d;
            vec_count_q <= vec_count_d;
            mux_din_q   <= mux_din_d;
            mux_sel_q   <= mux_sel_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    assign mux_din   = mux_din_q;
    assign mux_sel   = mux_sel_q;
    assign vec_valid = vec_valid_q;
    assign vec_count = vec_count_q;

endmodule
